// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the main control FSM
// that drives it.
package mult_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    DIV   = 3'd2,
    DONE  = 3'd3,
    DZERO = 3'd4
  } md_state_t;

  localparam int MD_ITER = 32;

  // R-type encodings decoded by the control FSM to launch this unit
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // rem < divisor on entry, so the difference always fits back into WIDTH bits
  always_comb begin
    shifted  = {rem, dividend_bit};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring on magnitudes)
// holding the HI/LO result registers.
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// MULT  | one Booth step per cycle, MD_ITER steps
// DIV   | one quotient bit per cycle, MD_ITER steps
// DONE  | hi/lo valid, done pulse
// DZERO | divide by zero requested, div_by_zero pulse
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(MD_ITER + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_ITER - 1);

  md_state_t state_q, state_d;

  // p_q/qreg_q are shared: {P, Q} for multiply, {remainder, dividend->quotient} for divide
  logic [WIDTH-1:0] p_q, qreg_q, mcand_q;
  logic             qm1_q;
  logic             sign_a_q, sign_b_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] booth_p, booth_q;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] div_rem, div_quot, rem_fix, quot_fix;
  logic             div_qbit;
  logic             last_step;

  assign last_step = (cnt_q == LAST_STEP);

  always_comb begin
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
  end

  // Sign-extended sum keeps P +/- M exact before the arithmetic shift
  always_comb begin
    booth_sum = {p_q[WIDTH-1], p_q};
    case ({qreg_q[0], qm1_q})
      2'b01:   booth_sum = {p_q[WIDTH-1], p_q} + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum = {p_q[WIDTH-1], p_q} - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum = {p_q[WIDTH-1], p_q};
    endcase
    booth_p = booth_sum[WIDTH:1];
    booth_q = {booth_sum[0], qreg_q[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (p_q),
    .divisor      (mcand_q),
    .dividend_bit (qreg_q[WIDTH-1]),
    .rem_next     (div_rem),
    .q_bit        (div_qbit)
  );

  always_comb begin
    div_quot = {qreg_q[WIDTH-2:0], div_qbit};
    quot_fix = (sign_a_q ^ sign_b_q) ? -div_quot : div_quot;
    rem_fix  = sign_a_q ? -div_rem : div_rem;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mult)                         state_d = MULT;
        else if (start_div && (b != '0))        state_d = DIV;
        else if (start_div)                     state_d = DZERO;
      end
      MULT: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      DZERO: begin
        div_by_zero = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q      <= '0;
      qreg_q   <= '0;
      mcand_q  <= '0;
      qm1_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_mult) begin
            mcand_q <= a;
            qreg_q  <= b;
            p_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (start_div && (b != '0)) begin
            mcand_q  <= abs_b;
            qreg_q   <= abs_a;
            p_q      <= '0;
            sign_a_q <= a[WIDTH-1];
            sign_b_q <= b[WIDTH-1];
            cnt_q    <= '0;
          end
        end
        MULT: begin
          p_q    <= booth_p;
          qreg_q <= booth_q;
          qm1_q  <= qreg_q[0];
          cnt_q  <= cnt_q + 1'b1;
          if (last_step) begin
            hi <= booth_p;
            lo <= booth_q;
          end
        end
        DIV: begin
          p_q    <= div_rem;
          qreg_q <= div_quot;
          cnt_q  <= cnt_q + 1'b1;
          if (last_step) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed-vector bench for mult_div: latency, busy window, signed results, divide by
// zero, ignored starts and asynchronous reset mid-operation.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  mult_div #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .a           (a),
    .b           (b),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Launch one operation; lat = edges from start edge to done (-1 on timeout),
  // busy_cnt = samples with busy high. Returns once the unit is back in IDLE.
  task automatic do_op(input logic sm, input logic sd, input logic [31:0] x,
                       input logic [31:0] y, output int lat, output int busy_cnt);
    @(negedge clock);
    a = x; b = y; start_mult = sm; start_div = sd;
    @(posedge clock); #1;
    start_mult = 1'b0; start_div = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    vectors++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    vectors++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    vectors++; if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    vec_t v[4];
    int lat, bc;
    v[0] = '{32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    v[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    v[3] = '{32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b0, v[i].a, v[i].b, lat, bc);
      vectors++; if (lat !== 32) begin errors++; $display("FAIL mult_latency[%0d]: got %0d expected 32", i, lat); end
      vectors++; if (bc !== 32) begin errors++; $display("FAIL mult_busy[%0d]: got %0d expected 32", i, bc); end
      vectors++; if (hi !== v[i].hi) begin errors++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi, v[i].hi); end
      vectors++; if (lo !== v[i].lo) begin errors++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo, v[i].lo); end
    end
  endtask

  task automatic test_div();
    vec_t v[5];
    int lat, bc;
    // {dividend, divisor, remainder, quotient}
    v[0] = '{32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    v[1] = '{32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[3] = '{32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    v[4] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, 1'b1, v[i].a, v[i].b, lat, bc);
      vectors++; if (lat !== 32) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 32", i, lat); end
      vectors++; if (bc !== 32) begin errors++; $display("FAIL div_busy[%0d]: got %0d expected 32", i, bc); end
      vectors++; if (hi !== v[i].hi) begin errors++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi, v[i].hi); end
      vectors++; if (lo !== v[i].lo) begin errors++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo, v[i].lo); end
    end
  endtask

  task automatic test_both_starts();
    int lat, bc;
    // 6 * -7 = -42; a divide would give q=0, r=6
    do_op(1'b1, 1'b1, 32'd6, 32'hFFFFFFF9, lat, bc);
    vectors++; if (lat !== 32) begin errors++; $display("FAIL both_latency: got %0d expected 32", lat); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL both_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    vectors++; if (lo !== 32'hFFFFFFD6) begin errors++; $display("FAIL both_lo: got %h expected %h", lo, 32'hFFFFFFD6); end
  endtask

  task automatic test_ignored_start();
    int lat;
    logic saw_dz;
    @(negedge clock);
    a = 32'h00010000; b = 32'h00030000; start_mult = 1'b1;
    @(posedge clock); #1;
    start_mult = 1'b0;
    lat = -1; saw_dz = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      start_div = (i == 10);
      if (i == 10) b = 32'h0;
      @(posedge clock); #1;
      if (div_by_zero) saw_dz = 1'b1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start_div = 1'b0;
    @(posedge clock); #1;
    vectors++; if (lat !== 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", lat); end
    vectors++; if (saw_dz !== 1'b0) begin errors++; $display("FAIL ignore_dz: got %b expected 0", saw_dz); end
    vectors++; if (hi !== 32'h00000003) begin errors++; $display("FAIL ignore_hi: got %h expected %h", hi, 32'h3); end
    vectors++; if (lo !== 32'h00000000) begin errors++; $display("FAIL ignore_lo: got %h expected %h", lo, 32'h0); end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    logic seen;
    do_op(1'b1, 1'b0, 32'h12345678, 32'hFFFFFFFF, lat, bc);
    vectors++; if (lo !== 32'hEDCBA988) begin errors++; $display("FAIL dz_preload_lo: got %h expected %h", lo, 32'hEDCBA988); end
    @(negedge clock);
    a = 32'd5; b = 32'd0; start_div = 1'b1;
    @(posedge clock); #1;
    start_div = 1'b0;
    vectors++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse: got %b expected 1", div_by_zero); end
    vectors++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL dz_busy_done: got %b expected 00", {busy, done}); end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      if (div_by_zero || busy || done) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL dz_after: got %b expected 0", seen); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
    vectors++; if (lo !== 32'hEDCBA988) begin errors++; $display("FAIL dz_lo: got %h expected %h", lo, 32'hEDCBA988); end
  endtask

  task automatic test_reset_mid_div();
    int lat, bc;
    logic seen;
    @(negedge clock);
    a = 32'd1000; b = 32'd3; start_div = 1'b1;
    @(posedge clock); #1;
    start_div = 1'b0;
    repeat (15) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected %h", hi, 32'h0); end
    vectors++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected %h", lo, 32'h0); end
    vectors++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b expected 00", {busy, done}); end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b expected 0", seen); end
    do_op(1'b1, 1'b0, 32'd6, 32'd7, lat, bc);
    vectors++; if (lat !== 32) begin errors++; $display("FAIL rstmid_mult_latency: got %0d expected 32", lat); end
    vectors++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_mult_hi: got %h expected %h", hi, 32'h0); end
    vectors++; if (lo !== 32'd42) begin errors++; $display("FAIL rstmid_mult_lo: got %h expected %h", lo, 32'd42); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_both_starts();
    test_ignored_start();
    test_div_by_zero();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
